// File: rtl/irq_vector_sequencer_if.sv
// Core-side signal bundle for the 6502 interrupt/reset entry sequencer.
// The sequencer takes the master view because it drives the bus while busy.
interface irq_vector_sequencer_if;
    logic        rdy;
    logic        nmi;
    logic        irq;
    logic        brk_req;
    logic        insn_boundary;
    logic        i_flag;
    logic [15:0] pc;
    logic [7:0]  sp;
    logic [7:0]  p;
    logic [7:0]  din;
    logic        busy;
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  dout;
    logic        sp_dec;
    logic        set_i;
    logic        pc_load;
    logic [15:0] pc_new;
    logic        seq_done;

    modport master (
        input  rdy, nmi, irq, brk_req, insn_boundary, i_flag, pc, sp, p, din,
        output busy, addr, rw, dout, sp_dec, set_i, pc_load, pc_new, seq_done
    );

    modport slave (
        output rdy, nmi, irq, brk_req, insn_boundary, i_flag, pc, sp, p, din,
        input  busy, addr, rw, dout, sp_dec, set_i, pc_load, pc_new, seq_done
    );
endinterface

// File: rtl/irq_vector_sequencer.sv
// 6502 RST/NMI/IRQ/BRK entry sequencer: arbitrates pending events at instruction
// boundaries, runs the 7-cycle push/vector-fetch sequence and hands the vector to PC.
module irq_vector_sequencer (
    input logic                    clk,
    input logic                    rst,
    irq_vector_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_S0,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_S4,
        ST_S5,
        ST_S6
    } state_e;

    typedef enum logic [1:0] {
        K_RST,
        K_NMI,
        K_IRQ,
        K_BRK
    } kind_e;

    localparam logic [15:0] VEC_NMI = 16'hFFFA;
    localparam logic [15:0] VEC_RST = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ = 16'hFFFE;

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    logic [15:0] vec_q, vec_d;
    logic [7:0]  vec_lo_q, vec_lo_d;
    logic        rst_pending_q, rst_pending_d;
    logic        nmi_pending_q, nmi_pending_d;
    logic        nmi_prev_q, nmi_prev_d;

    logic        nmi_edge;
    logic        nmi_clr;
    logic        irq_take;
    logic        nmi_vector_sel;

    logic [15:0] stack_addr;
    logic [7:0]  push_status;
    logic        kind_is_rst;

    assign irq_take       = ~bus.irq & ~bus.i_flag;
    // IRQ/BRK entries are hijacked to the NMI vector if an NMI edge arrived before the fetch.
    assign nmi_vector_sel = (kind_q == K_NMI) ||
                            (((kind_q == K_IRQ) || (kind_q == K_BRK)) && nmi_pending_q);

    always_comb begin : next_state
        state_d       = state_q;
        kind_d        = kind_q;
        vec_d         = vec_q;
        vec_lo_d      = vec_lo_q;
        rst_pending_d = rst_pending_q;
        nmi_prev_d    = bus.nmi;
        nmi_edge      = nmi_prev_q & ~bus.nmi;
        nmi_clr       = 1'b0;

        if (bus.rdy) begin
            case (state_q)
                ST_IDLE: begin
                    if (rst_pending_q) begin
                        kind_d        = K_RST;
                        state_d       = ST_S0;
                        rst_pending_d = 1'b0;
                    end else if (bus.insn_boundary) begin
                        if (nmi_pending_q) begin
                            kind_d  = K_NMI;
                            state_d = ST_S0;
                        end else if (bus.brk_req) begin
                            kind_d  = K_BRK;
                            state_d = ST_S0;
                        end else if (irq_take) begin
                            kind_d  = K_IRQ;
                            state_d = ST_S0;
                        end
                    end
                end
                ST_S0: state_d = ST_S1;
                ST_S1: state_d = ST_S2;
                ST_S2: state_d = ST_S3;
                ST_S3: state_d = ST_S4;
                ST_S4: begin
                    state_d = ST_S5;
                    if (nmi_vector_sel) begin
                        vec_d   = VEC_NMI;
                        nmi_clr = 1'b1;
                    end else if (kind_q == K_RST) begin
                        vec_d = VEC_RST;
                    end else begin
                        vec_d = VEC_IRQ;
                    end
                end
                ST_S5: begin
                    vec_lo_d = bus.din;
                    state_d  = ST_S6;
                end
                ST_S6: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        // A fresh edge wins over a same-cycle clear so no NMI is lost.
        nmi_pending_d = nmi_edge | (nmi_pending_q & ~nmi_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            kind_q        <= K_RST;
            vec_q         <= '0;
            vec_lo_q      <= '0;
            rst_pending_q <= 1'b1;
            nmi_pending_q <= 1'b0;
            nmi_prev_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            kind_q        <= kind_d;
            vec_q         <= vec_d;
            vec_lo_q      <= vec_lo_d;
            rst_pending_q <= rst_pending_d;
            nmi_pending_q <= nmi_pending_d;
            nmi_prev_q    <= nmi_prev_d;
        end
    end

    assign stack_addr  = {8'h01, bus.sp};
    assign kind_is_rst = (kind_q == K_RST);
    assign push_status = {bus.p[7:6], 1'b1, (kind_q == K_BRK), bus.p[3:0]};

    always_comb begin : bus_outputs
        bus.busy     = 1'b0;
        bus.addr     = '0;
        bus.rw       = 1'b1;
        bus.dout     = '0;
        bus.sp_dec   = 1'b0;
        bus.set_i    = 1'b0;
        bus.pc_load  = 1'b0;
        bus.pc_new   = '0;
        bus.seq_done = 1'b0;

        case (state_q)
            ST_S0, ST_S1: begin
                bus.busy = 1'b1;
                bus.addr = bus.pc;
            end
            ST_S2: begin
                bus.busy   = 1'b1;
                bus.addr   = stack_addr;
                bus.sp_dec = bus.rdy;
                if (!kind_is_rst) begin
                    bus.rw   = 1'b0;
                    bus.dout = bus.pc[15:8];
                end
            end
            ST_S3: begin
                bus.busy   = 1'b1;
                bus.addr   = stack_addr;
                bus.sp_dec = bus.rdy;
                if (!kind_is_rst) begin
                    bus.rw   = 1'b0;
                    bus.dout = bus.pc[7:0];
                end
            end
            ST_S4: begin
                bus.busy   = 1'b1;
                bus.addr   = stack_addr;
                bus.sp_dec = bus.rdy;
                if (!kind_is_rst) begin
                    bus.rw   = 1'b0;
                    bus.dout = push_status;
                end
            end
            ST_S5: begin
                bus.busy = 1'b1;
                bus.addr = vec_q;
            end
            ST_S6: begin
                bus.busy     = 1'b1;
                bus.addr     = vec_q + 16'd1;
                bus.pc_new   = {bus.din, vec_lo_q};
                bus.pc_load  = bus.rdy;
                bus.set_i    = bus.rdy;
                bus.seq_done = bus.rdy;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_irq_vector_sequencer.sv
// Bench for irq_vector_sequencer: directed scenarios plus randomized traffic, all
// checked every cycle against a sequence-position reference model.
module tb_irq_vector_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    irq_vector_sequencer_if bus_if();

    irq_vector_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // stimulus
    logic        s_rst, s_rdy, s_nmi, s_irq, s_brk, s_bnd, s_if;
    logic [15:0] s_pc;
    logic [7:0]  s_p, sp_reg;

    // model: pos 0 = idle, 1..7 = n-th cycle of the entry sequence
    int          pos;
    int          mkind;      // 0 RST, 1 NMI, 2 IRQ, 3 BRK
    bit          m_rstp, m_nmip, m_nmiprev;
    logic [15:0] m_vec;
    logic [7:0]  m_veclo;

    // observations
    int          cyc, n_done, n_spdec, n_busy, n_seti, load_cyc;
    logic [15:0] last_pcnew, last_vec_addr;
    logic [24:0] wlog[$];

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        case (a)
            16'hFFFA: return 8'hCD;
            16'hFFFB: return 8'hAB;
            16'hFFFC: return 8'h34;
            16'hFFFD: return 8'h12;
            16'hFFFE: return 8'h78;
            16'hFFFF: return 8'h56;
            default:  return 8'($urandom);
        endcase
    endfunction

    task automatic idle();
        s_rst = 1'b0; s_rdy = 1'b1; s_nmi = 1'b1; s_irq = 1'b1;
        s_brk = 1'b0; s_bnd = 1'b0; s_if = 1'b1;
    endtask

    task automatic step();
        logic        e_busy, e_rw, e_spdec, e_last;
        logic [15:0] e_addr, e_pcnew;
        logic [7:0]  e_dout, din;
        bit          nedge, clr;

        e_busy = (pos != 0);
        e_addr = 16'h0000;
        e_rw   = 1'b1;
        e_dout = 8'h00;
        if (pos == 1 || pos == 2) begin
            e_addr = s_pc;
        end else if (pos >= 3 && pos <= 5) begin
            e_addr = 16'h0100 | {8'h00, sp_reg};
            if (mkind != 0) begin
                e_rw = 1'b0;
                if (pos == 3)      e_dout = s_pc[15:8];
                else if (pos == 4) e_dout = s_pc[7:0];
                else               e_dout = (s_p & 8'hCF) | 8'h20 | ((mkind == 3) ? 8'h10 : 8'h00);
            end
        end else if (pos == 6) begin
            e_addr = m_vec;
        end else if (pos == 7) begin
            e_addr = m_vec + 16'd1;
        end
        din     = (pos >= 6) ? mem_rd(e_addr) : 8'($urandom);
        e_spdec = s_rdy && pos >= 3 && pos <= 5;
        e_last  = s_rdy && pos == 7;
        e_pcnew = (pos == 7) ? {din, m_veclo} : 16'h0000;

        rst                  = s_rst;
        bus_if.rdy           = s_rdy;
        bus_if.nmi           = s_nmi;
        bus_if.irq           = s_irq;
        bus_if.brk_req       = s_brk;
        bus_if.insn_boundary = s_bnd;
        bus_if.i_flag        = s_if;
        bus_if.pc            = s_pc;
        bus_if.sp            = sp_reg;
        bus_if.p             = s_p;
        bus_if.din           = din;

        @(negedge clk);
        check("busy",     32'(bus_if.busy),     32'(e_busy));
        check("addr",     32'(bus_if.addr),     32'(e_addr));
        check("rw",       32'(bus_if.rw),       32'(e_rw));
        check("dout",     32'(bus_if.dout),     32'(e_dout));
        check("sp_dec",   32'(bus_if.sp_dec),   32'(e_spdec));
        check("set_i",    32'(bus_if.set_i),    32'(e_last));
        check("pc_load",  32'(bus_if.pc_load),  32'(e_last));
        check("seq_done", 32'(bus_if.seq_done), 32'(e_last));
        check("pc_new",   32'(bus_if.pc_new),   32'(e_pcnew));

        if (bus_if.sp_dec) begin
            n_spdec++;
            wlog.push_back({bus_if.addr, bus_if.rw, bus_if.dout});
        end
        if (bus_if.busy)  n_busy++;
        if (bus_if.set_i) n_seti++;
        if (bus_if.pc_load) begin
            n_done++;
            last_pcnew = bus_if.pc_new;
            load_cyc   = cyc;
        end
        if (pos == 6) last_vec_addr = bus_if.addr;

        @(posedge clk);
        if (s_rst) begin
            pos = 0; m_rstp = 1; m_nmip = 0; m_nmiprev = 1; m_veclo = 8'h00;
        end else begin
            nedge     = m_nmiprev && !s_nmi;
            clr       = 0;
            m_nmiprev = s_nmi;
            if (s_rdy) begin
                if (pos == 0) begin
                    if (m_rstp) begin
                        mkind = 0; pos = 1; m_rstp = 0;
                    end else if (s_bnd) begin
                        if (m_nmip)               begin mkind = 1; pos = 1; end
                        else if (s_brk)           begin mkind = 3; pos = 1; end
                        else if (!s_irq && !s_if) begin mkind = 2; pos = 1; end
                    end
                end else if (pos == 5) begin
                    if (mkind == 1 || (mkind >= 2 && m_nmip)) begin
                        m_vec = 16'hFFFA; clr = 1;
                    end else begin
                        m_vec = (mkind == 0) ? 16'hFFFC : 16'hFFFE;
                    end
                    pos = 6;
                end else if (pos == 6) begin
                    m_veclo = din; pos = 7;
                end else if (pos == 7) begin
                    pos = 0;
                end else begin
                    pos++;
                end
            end
            m_nmip = nedge || (m_nmip && !clr);
        end
        if (e_spdec) sp_reg = sp_reg - 8'd1;
        cyc++;
        #1;
    endtask

    task automatic run_until(input int target);
        for (int i = 0; i < 30 && pos != target; i++) step();
    endtask

    int rel, b0, d0, s0, st, n0;

    initial begin
        pos = 0; mkind = 0; m_rstp = 1; m_nmip = 0; m_nmiprev = 1;
        m_vec = 16'h0000; m_veclo = 8'h00;
        cyc = 0; n_done = 0; n_spdec = 0; n_busy = 0; n_seti = 0; load_cyc = 0;
        last_pcnew = 16'h0000; last_vec_addr = 16'h0000;
        idle();
        s_rst = 1'b1; sp_reg = 8'hFD; s_pc = 16'h0000; s_p = 8'h00;
        rst = 1'b1;
        bus_if.rdy = 1'b1; bus_if.nmi = 1'b1; bus_if.irq = 1'b1; bus_if.brk_req = 1'b0;
        bus_if.insn_boundary = 1'b0; bus_if.i_flag = 1'b1; bus_if.pc = 16'h0000;
        bus_if.sp = 8'hFD; bus_if.p = 8'h00; bus_if.din = 8'h00;
        @(posedge clk); #1;

        // reset release runs an RST sequence with reads in place of pushes
        step(); step();
        s_rst = 1'b0; wlog.delete(); rel = cyc;
        repeat (8) step();
        check("rst_push_cnt", 32'(wlog.size()), 32'd3);
        check("rst_push0", 32'(wlog[0]), {7'd0, 16'h01FD, 1'b1, 8'h00});
        check("rst_push1", 32'(wlog[1]), {7'd0, 16'h01FC, 1'b1, 8'h00});
        check("rst_push2", 32'(wlog[2]), {7'd0, 16'h01FB, 1'b1, 8'h00});
        check("rst_vector", 32'(last_pcnew), 32'h1234);
        check("rst_latency", 32'(load_cyc - rel), 32'd7);

        // IRQ entry
        idle(); s_pc = 16'h8003; s_p = 8'h00; sp_reg = 8'hFF; s_if = 1'b0; s_irq = 1'b0; s_bnd = 1'b1;
        wlog.delete(); n0 = n_seti;
        step(); s_irq = 1'b1; s_bnd = 1'b0;
        repeat (7) step();
        check("irq_push_cnt", 32'(wlog.size()), 32'd3);
        check("irq_push0", 32'(wlog[0]), {7'd0, 16'h01FF, 1'b0, 8'h80});
        check("irq_push1", 32'(wlog[1]), {7'd0, 16'h01FE, 1'b0, 8'h03});
        check("irq_push2", 32'(wlog[2]), {7'd0, 16'h01FD, 1'b0, 8'h20});
        check("irq_vec_addr", 32'(last_vec_addr), 32'hFFFE);
        check("irq_vector", 32'(last_pcnew), 32'h5678);
        check("irq_set_i", 32'(n_seti - n0), 32'd1);

        // masked IRQ never starts
        idle(); s_irq = 1'b0; s_if = 1'b1; s_bnd = 1'b1; b0 = n_busy;
        repeat (10) step();
        check("irq_masked", 32'(n_busy - b0), 32'd0);

        // BRK pushes B=1 and the unused bit
        idle(); s_p = 8'hC1; s_brk = 1'b1; s_bnd = 1'b1; wlog.delete();
        step(); s_brk = 1'b0; s_bnd = 1'b0;
        repeat (7) step();
        check("brk_status", 32'(wlog[2][7:0]), 32'hF1);

        // BRK hijacked by an NMI edge during S3
        idle(); s_p = 8'h00; s_brk = 1'b1; s_bnd = 1'b1; wlog.delete();
        step(); s_brk = 1'b0; s_bnd = 1'b0;
        run_until(4);
        s_nmi = 1'b0;
        run_until(0);
        check("hijack_vec_addr", 32'(last_vec_addr), 32'hFFFA);
        check("hijack_status", 32'(wlog[2][7:0]), 32'h30);
        check("hijack_vector", 32'(last_pcnew), 32'hABCD);
        s_bnd = 1'b1; b0 = n_busy;
        repeat (4) step();
        check("hijack_cleared", 32'(n_busy - b0), 32'd0);

        // NMI held low is a single event
        idle(); step();
        s_nmi = 1'b0; s_bnd = 1'b1; d0 = n_done;
        repeat (20) step();
        check("nmi_once", 32'(n_done - d0), 32'd1);

        // second NMI edge during S6 is taken at the next boundary
        idle(); step();
        d0 = n_done; s_brk = 1'b1; s_bnd = 1'b1;
        step(); s_brk = 1'b0; s_bnd = 1'b0;
        run_until(7);
        s_nmi = 1'b0; step();
        s_bnd = 1'b1;
        repeat (10) step();
        check("nmi_second", 32'(n_done - d0), 32'd2);
        check("nmi_second_vec", 32'(last_vec_addr), 32'hFFFA);

        // three stall cycles in S2
        idle(); s_if = 1'b0; s_irq = 1'b0; s_bnd = 1'b1; st = cyc; s0 = n_spdec;
        step(); s_irq = 1'b1; s_bnd = 1'b0;
        run_until(3);
        s_rdy = 1'b0; repeat (3) step(); s_rdy = 1'b1;
        run_until(0);
        check("stall_sp_dec", 32'(n_spdec - s0), 32'd3);
        check("stall_latency", 32'(load_cyc - st), 32'd10);

        // reset during S4 aborts and reruns as RST
        idle(); s_brk = 1'b1; s_bnd = 1'b1;
        step(); s_brk = 1'b0; s_bnd = 1'b0;
        run_until(5);
        s_rst = 1'b1; step(); s_rst = 1'b0;
        check("abort_busy", 32'(bus_if.busy), 32'd0);
        wlog.delete();
        repeat (8) step();
        check("abort_rst_vector", 32'(last_pcnew), 32'h1234);
        check("abort_rst_read", 32'(wlog[0][8]), 32'd1);

        // randomized traffic
        idle();
        repeat (3000) begin
            s_rst = ($urandom_range(0, 299) == 0);
            s_rdy = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 11) == 0) s_nmi = ~s_nmi;
            s_irq = ($urandom_range(0, 2) != 0);
            s_brk = ($urandom_range(0, 5) == 0);
            s_bnd = ($urandom_range(0, 2) == 0);
            s_if  = $urandom_range(0, 1) == 1;
            s_pc  = 16'($urandom);
            s_p   = 8'($urandom);
            if (pos == 0 && $urandom_range(0, 9) == 0) sp_reg = 8'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
